// File: rtl/qout_uart_tx.sv
// Q-register output UART: bytes written by the CPU are queued in a small FIFO and
// sent as 8N1 frames. Define QOUT_UART_PARITY_EN to add an even-parity bit (8E1).
module qout_uart_tx #(
    parameter int CLKS_PER_BIT = 4,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          qStrobe,
    input  logic [7:0]                    qData,
    output logic                          tx,
    output logic                          busy,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [7:0]    BIT_LAST = 8'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] FULL     = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef QOUT_UART_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    timer_q, timer_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    frame_q, frame_d;
    logic          tx_q, tx_d;
    logic          busy_q, busy_d;
    logic          ovf_q, ovf_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [7:0]    mem_d [FIFO_DEPTH];
    logic          bit_end;
    logic          pop;
    logic          push;

    // Frame sequencing, FIFO bookkeeping and next-cycle output values.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q + 8'd1;
        idx_d   = idx_q;
        frame_d = frame_q;
        pop     = 1'b0;
        bit_end = (timer_q == BIT_LAST);

        case (state_q)
            S_IDLE: begin
                timer_d = 8'd0;
                if (count_q != '0) begin
                    pop     = 1'b1;
                    frame_d = mem_q[rptr_q];
                    state_d = S_START;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                if (bit_end) begin
                    timer_d = 8'd0;
                    idx_d   = 3'd0;
                    state_d = S_DATA;
                end else begin
                    state_d = S_START;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    timer_d = 8'd0;
                    if (idx_q == 3'd7) begin
                        idx_d = 3'd0;
`ifdef QOUT_UART_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    idx_d = idx_q;
                end
            end
`ifdef QOUT_UART_PARITY_EN
            S_PARITY: begin
                if (bit_end) begin
                    timer_d = 8'd0;
                    state_d = S_STOP;
                end else begin
                    state_d = S_PARITY;
                end
            end
`endif
            S_STOP: begin
                // Chain straight into the next start bit when more bytes are waiting.
                if (bit_end) begin
                    timer_d = 8'd0;
                    if (count_q != '0) begin
                        pop     = 1'b1;
                        frame_d = mem_q[rptr_q];
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    state_d = S_STOP;
                end
            end
            default: begin
                timer_d = 8'd0;
                idx_d   = 3'd0;
                state_d = S_IDLE;
            end
        endcase

        push   = qStrobe && ((count_q != FULL) || pop);
        mem_d  = mem_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (push) begin
            mem_d[wptr_q] = qData;
            wptr_d        = wptr_q + AW'(1);
            ovf_d         = ovf_q;
        end else if (qStrobe) begin
            ovf_d = 1'b1;
        end else begin
            ovf_d = ovf_q;
        end
        if (pop) begin
            rptr_d = rptr_q + AW'(1);
        end else begin
            rptr_d = rptr_q;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = frame_d[idx_d];
`ifdef QOUT_UART_PARITY_EN
            S_PARITY: tx_d = ^frame_d;
`endif
            S_STOP:   tx_d = 1'b1;
            default:  tx_d = 1'b1;
        endcase

        busy_d = (state_d != S_IDLE) || (count_d != '0);
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            timer_q <= 8'd0;
            idx_q   <= 3'd0;
            frame_q <= 8'd0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
            count_q <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            idx_q   <= idx_d;
            frame_q <= frame_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            ovf_q   <= ovf_d;
            count_q <= count_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
        end
    end

    // FIFO storage needs no reset: occupancy is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign tx       = tx_q;
    assign busy     = busy_q;
    assign overflow = ovf_q;
    assign count    = count_q;

endmodule

// File: tb/tb_qout_uart_tx.sv
// Randomized and directed bench for qout_uart_tx, compared cycle by cycle against a
// queue-based frame model; honours QOUT_UART_PARITY_EN like the design.
module tb_qout_uart_tx;

    localparam int C  = 4;
    localparam int D  = 4;
    localparam int CW = 3;
`ifdef QOUT_UART_PARITY_EN
    localparam int FL = 11 * C;
`else
    localparam int FL = 10 * C;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          qStrobe = 1'b0;
    logic [7:0]    qData = 8'd0;
    logic          tx, busy, overflow;
    logic [CW-1:0] count;

    int n_checks = 0;
    int n_fail   = 0;

    byte unsigned m_q[$];
    bit           m_active;
    int           m_f;
    bit   [7:0]   m_cur;
    bit           m_ovf;

    logic lg [0:4095];
    logic bz [0:4095];
    int   lg_n;

    qout_uart_tx #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
        .clk(clk), .reset(reset), .qStrobe(qStrobe), .qData(qData),
        .tx(tx), .busy(busy), .overflow(overflow), .count(count)
    );

    always #5 clk = ~clk;

    // Frame bit b of the byte in flight: 0 = start, 1..8 = data LSB first, then parity/stop.
    function automatic logic exp_tx();
        int b;
        if (!m_active) return 1'b1;
        b = m_f / C;
        if (b == 0) return 1'b0;
        if (b <= 8) return m_cur[b-1];
`ifdef QOUT_UART_PARITY_EN
        if (b == 9) return ^m_cur;
`endif
        return 1'b1;
    endfunction

    function automatic logic [CW+2:0] exp_vec();
        return {exp_tx(), (m_active || m_q.size() > 0), m_ovf, CW'(m_q.size())};
    endfunction

    task automatic model_edge(input logic rst, input logic stb, input logic [7:0] d);
        int sz;
        bit popped;
        sz = m_q.size();
        popped = 1'b0;
        if (rst) begin
            m_q.delete();
            m_active = 1'b0;
            m_f = 0;
            m_ovf = 1'b0;
            return;
        end
        if (m_active) begin
            if (m_f == FL - 1) begin
                if (sz > 0) begin
                    m_cur = m_q.pop_front();
                    m_f = 0;
                    popped = 1'b1;
                end else begin
                    m_active = 1'b0;
                end
            end else begin
                m_f++;
            end
        end else if (sz > 0) begin
            m_cur = m_q.pop_front();
            m_active = 1'b1;
            m_f = 0;
            popped = 1'b1;
        end
        if (stb) begin
            if (sz < D || popped) m_q.push_back(d);
            else m_ovf = 1'b1;
        end
    endtask

    task automatic step(input logic stb, input logic [7:0] d, input logic rst);
        qStrobe = stb;
        qData   = d;
        reset   = rst;
        @(posedge clk);
        model_edge(rst, stb, d);
        #1;
        if (lg_n < 4096) begin
            lg[lg_n] = tx;
            bz[lg_n] = busy;
            lg_n++;
        end
    endtask

    function automatic int first_low();
        for (int i = 0; i < lg_n; i++) if (lg[i] === 1'b0) return i;
        return 0;
    endfunction

    function automatic logic [7:0] dec(input int s);
        logic [7:0] r;
        for (int k = 0; k < 8; k++) r[k] = lg[s + C*(k+1) + C/2];
        return r;
    endfunction

    task automatic do_reset();
        step(1'b0, 8'd0, 1'b1);
        step(1'b0, 8'd0, 1'b1);
        step(1'b0, 8'd0, 1'b0);
        lg_n = 0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({tx, busy, overflow, count} !== {1'b1, 1'b0, 1'b0, 3'd0}) begin
            n_fail++;
            $display("FAIL reset_state: got %b want %b", {tx, busy, overflow, count}, {1'b1, 1'b0, 1'b0, 3'd0});
        end
    endtask

    task automatic test_single(input logic [7:0] b, input string nm);
        int s, fall;
        do_reset();
        step(1'b1, b, 1'b0);
        for (int i = 0; i < FL + 8; i++) begin
            step(1'b0, 8'd0, 1'b0);
            n_checks++;
            if ({tx, busy, overflow, count} !== exp_vec()) begin
                n_fail++;
                $display("FAIL %s_cycle%0d: got %b want %b", nm, i, {tx, busy, overflow, count}, exp_vec());
            end
        end
        s = first_low();
        fall = 0;
        for (int i = s; i < lg_n; i++) if (fall == 0 && bz[i] === 1'b0) fall = i;
        n_checks++;
        if (s !== 1) begin n_fail++; $display("FAIL %s_start_latency: got %0d want 1", nm, s); end
        n_checks++;
        if (dec(s) !== b) begin n_fail++; $display("FAIL %s_data: got %h want %h", nm, dec(s), b); end
        n_checks++;
        if (fall - s !== FL) begin n_fail++; $display("FAIL %s_busy_len: got %0d want %0d", nm, fall - s, FL); end
`ifdef QOUT_UART_PARITY_EN
        n_checks++;
        if (lg[s + 9*C + C/2] !== ^b) begin
            n_fail++;
            $display("FAIL %s_parity: got %b want %b", nm, lg[s + 9*C + C/2], ^b);
        end
`endif
    endtask

    task automatic test_back_to_back();
        int s, peak;
        do_reset();
        peak = 0;
        for (int i = 0; i < 3 * FL + 10; i++) begin
            if (i < 3) step(1'b1, 8'(i + 1), 1'b0);
            else step(1'b0, 8'd0, 1'b0);
            if (int'(count) > peak) peak = int'(count);
            n_checks++;
            if ({tx, busy, overflow, count} !== exp_vec()) begin
                n_fail++;
                $display("FAIL b2b_cycle%0d: got %b want %b", i, {tx, busy, overflow, count}, exp_vec());
            end
        end
        s = first_low();
        n_checks++;
        if (peak !== 2) begin n_fail++; $display("FAIL b2b_peak_count: got %0d want 2", peak); end
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (dec(s + k*FL) !== 8'(k + 1)) begin
                n_fail++;
                $display("FAIL b2b_frame%0d: got %h want %h", k, dec(s + k*FL), 8'(k + 1));
            end
        end
        for (int k = 1; k < 3; k++) begin
            n_checks++;
            if ({lg[s + k*FL - 1], lg[s + k*FL]} !== 2'b10) begin
                n_fail++;
                $display("FAIL b2b_gap%0d: got %b want 10", k, {lg[s + k*FL - 1], lg[s + k*FL]});
            end
        end
    endtask

    task automatic test_overflow();
        int s;
        do_reset();
        for (int i = 0; i < 6 * FL; i++) begin
            if (i < 6) step(1'b1, 8'(8'h10 + i), 1'b0);
            else step(1'b0, 8'd0, 1'b0);
            n_checks++;
            if ({tx, busy, overflow, count} !== exp_vec()) begin
                n_fail++;
                $display("FAIL ovf_cycle%0d: got %b want %b", i, {tx, busy, overflow, count}, exp_vec());
            end
            if (i == 5) begin
                n_checks++;
                if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b want 1", overflow); end
            end
        end
        s = first_low();
        for (int k = 0; k < 5; k++) begin
            n_checks++;
            if (dec(s + k*FL) !== 8'(8'h10 + k)) begin
                n_fail++;
                $display("FAIL ovf_frame%0d: got %h want %h", k, dec(s + k*FL), 8'(8'h10 + k));
            end
        end
        n_checks++;
        if ({bz[s + 5*FL], lg[s + 5*FL], overflow} !== 3'b011) begin
            n_fail++;
            $display("FAIL ovf_no_sixth: got %b want 011", {bz[s + 5*FL], lg[s + 5*FL], overflow});
        end
    endtask

    task automatic test_full_pop();
        int guard;
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h20 + i), 1'b0);
        guard = 0;
        while (!(m_active && m_f == FL - 1 && m_q.size() == D) && guard < 200) begin
            step(1'b0, 8'd0, 1'b0);
            guard++;
        end
        n_checks++;
        if (guard >= 200) begin n_fail++; $display("FAIL fullpop_wait: got timeout want stop edge"); end
        step(1'b1, 8'h25, 1'b0);
        n_checks++;
        if ({count, overflow} !== {3'd4, 1'b0}) begin
            n_fail++;
            $display("FAIL fullpop_accept: got count=%0d ovf=%b want count=4 ovf=0", count, overflow);
        end
        for (int i = 0; i < 6 * FL; i++) begin
            step(1'b0, 8'd0, 1'b0);
            n_checks++;
            if ({tx, busy, overflow, count} !== exp_vec()) begin
                n_fail++;
                $display("FAIL fullpop_cycle%0d: got %b want %b", i, {tx, busy, overflow, count}, exp_vec());
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        int guard;
        do_reset();
        step(1'b1, 8'hFF, 1'b0);
        guard = 0;
        while (!(m_active && m_f == 4*C + 1) && guard < 100) begin
            step(1'b0, 8'd0, 1'b0);
            guard++;
        end
        step(1'b1, 8'h5A, 1'b1);
        n_checks++;
        if ({tx, busy, overflow, count} !== {1'b1, 1'b0, 1'b0, 3'd0}) begin
            n_fail++;
            $display("FAIL midreset_state: got %b want %b", {tx, busy, overflow, count}, {1'b1, 1'b0, 1'b0, 3'd0});
        end
        step(1'b0, 8'd0, 1'b0);
        lg_n = 0;
        test_single(8'h00, "after_reset");
    endtask

    task automatic test_random();
        int burst;
        logic stb, rst;
        do_reset();
        burst = 0;
        for (int i = 0; i < 3000; i++) begin
            stb = 1'b0;
            if (burst > 0) begin
                stb = 1'b1;
                burst--;
            end else if ($urandom_range(0, 99) < 4) begin
                stb = 1'b1;
            end
            if ($urandom_range(0, 199) == 0) burst = $urandom_range(2, 7);
            rst = ($urandom_range(0, 999) == 0);
            step(stb, 8'($urandom_range(0, 255)), rst);
            n_checks++;
            if ({tx, busy, overflow, count} !== exp_vec()) begin
                n_fail++;
                $display("FAIL random_cycle%0d: got %b want %b", i, {tx, busy, overflow, count}, exp_vec());
            end
        end
    endtask

    initial begin
        lg_n = 0;
        test_reset();
        test_single(8'hA5, "single_a5");
        test_back_to_back();
        test_overflow();
        test_full_pop();
        test_reset_mid_frame();
        test_single(8'h07, "parity_07");
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/qout_uart_tx.md
QOUT_UART_TX -- requirements
Module: qout_uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 4, meaning clock cycles per serial bit; legal range 2..255.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning byte entries buffered; power of two, 2..16.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port qStrobe, input, 1 bit: push request; the CPU asserts it for one cycle when the Q register is written.
REQ-006 SHALL have port qData, input, 8 bits: byte to push, sampled on the edge where qStrobe=1.
REQ-007 SHALL have port tx, output, 1 bit: serial line, idle high, registered.
REQ-008 SHALL have port busy, output, 1 bit: high when the FSM is not IDLE or the FIFO is non-empty.
REQ-009 SHALL have port overflow, output, 1 bit: sticky flag for a dropped push.
REQ-010 SHALL have port count, output, $clog2(FIFO_DEPTH)+1 bits: FIFO occupancy.

Function
REQ-011 SHALL store bytes in a FIFO_DEPTH circular buffer with wrapping read/write pointers; order is first-in first-out.
REQ-012 SHALL push qData on an edge with qStrobe=1 when count<FIFO_DEPTH, or when count==FIFO_DEPTH and a pop occurs on the same edge.
REQ-013 SHALL drop a push made when the FIFO is full with no same-edge pop, and set overflow=1 from the next cycle until reset.
REQ-014 SHALL, on a simultaneous push and pop, leave count unchanged and advance both pointers.
REQ-015 SHALL have the FSM states IDLE, START, DATA, PARITY (macro only), and STOP.
REQ-016 SHALL, in IDLE with count>0, pop the head byte into a shift register on the next edge and enter START.
- Consequence: a push at edge N into an empty, idle block drives tx low after edge N+1.
REQ-017 SHALL hold each bit on tx for exactly CLKS_PER_BIT cycles using a bit-timer counter that reloads on every state or bit change.
REQ-018 SHALL transmit, in order:
- START: tx=0.
- DATA: 8 bits, LSB first; a 3-bit index counts 0..7.
- STOP: tx=1.
REQ-019 SHALL, at the end of STOP, pop the next byte and go to START on the same edge if count>0 (back-to-back frames, no idle gap); otherwise it SHALL go to IDLE.
REQ-020 SHALL keep tx=1 in IDLE.
REQ-021 SHALL keep count equal to the number of bytes accepted and not yet popped; the byte in flight is not counted.

Reset
REQ-022 SHALL, on reset=1 at an edge, set: state=IDLE, tx=1, pointers=0, count=0, overflow=0, busy=0, and bit timer and index = 0.
REQ-023 SHALL abort a frame in progress on reset mid-frame: tx returns high on the next cycle and buffered bytes are discarded.
REQ-024 SHALL ignore qStrobe on any edge where reset=1.

Configuration
REQ-025 SHALL, when macro QOUT_UART_PARITY_EN is defined, insert a PARITY state between DATA and STOP that drives the even parity of the 8 data bits for CLKS_PER_BIT cycles; frame = 11 bits.
REQ-026 SHALL, without QOUT_UART_PARITY_EN, go directly from DATA to STOP; frame = 10 bits; no parity logic is synthesised.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-027 SHALL cover single byte: push 0xA5 at edge N. Required response:
- tx low over cycles N+1..N+4.
- Then bits 1,0,1,0,0,1,0,1, each 4 cycles.
- Then high 4 cycles.
- busy falls after 40 cycles, or 44 with parity; parity bit = 0 for 0xA5.
REQ-028 SHALL cover back-to-back: push 0x01, 0x02, 0x03 on consecutive edges. Required response:
- count peaks at 2.
- Three frames appear with no idle cycle between a stop bit and the next start bit.
REQ-029 SHALL cover overflow: push 6 bytes 0x10..0x15 on consecutive edges. Required response:
- 0x10 goes in flight; 0x11..0x14 fill the FIFO.
- 0x15 is dropped and overflow=1.
- Only 0x10..0x14 are transmitted.
REQ-030 SHALL cover full with simultaneous pop: with count=4, push exactly on the STOP-to-START edge. Required response: the byte is accepted, count stays 4, and overflow stays 0.
REQ-031 SHALL cover reset mid-frame: assert reset during DATA bit 3 of 0xFF. Required response:
- Next cycle tx=1, count=0, busy=0, overflow=0.
- A subsequent push of 0x00 produces a clean frame.
REQ-032 SHALL cover parity with the macro defined: push 0x07. Required response: parity bit=1 and the frame is 44 cycles.
